load_store_unit: RTL

Memory-access stage directly downstream of the ALU. Takes the ALU result as the effective address, performs byte/half/word loads and stores through a ready-based data-memory handshake, and returns sign/zero-extended load data to the writeback mux. Stalls the single-cycle core (PC and register-file write held) while an access is outstanding. Flags misaligned or illegal accesses and bus timeouts.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_align.sv | 49 ++++
 rtl/load_store_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM states,
// timeout counter width and the access legality rule.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } lsu_state_e;

    // True when funct3 is defined for this direction and the address is
    // naturally aligned for the access size.
    function automatic logic access_ok(input logic [2:0] f3,
                                       input logic [1:0] addr_lo,
                                       input logic       is_store);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = !addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            F3_BU:   ok = !is_store;
            F3_HU:   ok = !is_store && !addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enable/data steering and load lane
// extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_addr_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] lane;

    assign lane = ld_rdata_i >> {ld_addr_i, 3'b000};

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch.
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
        case (st_funct3_i[1:0])
            2'b00: begin
                st_be_o    = 4'b0001 << st_addr_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            2'b01: begin
                st_be_o    = st_addr_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_data_o = ld_rdata_i;
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{lane[7]}}, lane[7:0]};
            F3_BU:   ld_data_o = {24'h0, lane[7:0]};
            F3_H:    ld_data_o = {{16{lane[15]}}, lane[15:0]};
            F3_HU:   ld_data_o = {16'h0, lane[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: issues one ready-handshaked data-memory access per
// load/store, stalls the core while it is outstanding, and flags faults.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUResult_ALU,
    input  logic [31:0] Data2_RF,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ReadData_LSU,
    output logic        Stall_LSU,
    output logic        Misaligned_LSU,
    output logic        BusError_LSU
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             req_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic [2:0]       f3_q;
    logic [1:0]       lo_q;
    logic [31:0]      data_q;
    logic             bus_err_q;

    logic        access_v;
    logic        legal;
    logic        illegal;
    logic        issue;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    assign access_v = MemRead ^ MemWrite;
    assign legal    = access_v && access_ok(funct3, ALUResult_ALU[1:0], MemWrite);
    assign illegal  = (MemRead && MemWrite) || (access_v && !legal);
    assign issue    = (state_q == ST_IDLE) && legal;

    lsu_align u_align (
        .st_funct3_i (funct3),
        .st_addr_i   (ALUResult_ALU[1:0]),
        .st_data_i   (Data2_RF),
        .st_be_o     (st_be),
        .st_wdata_o  (st_wdata),
        .ld_funct3_i (f3_q),
        .ld_addr_i   (lo_q),
        .ld_rdata_i  (mem_rdata),
        .ld_data_o   (ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: every register, including the latched request fields, has
            // a defined reset value so the bus sees all-zero after reset.
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            f3_q      <= '0;
            lo_q      <= '0;
            data_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        addr_q  <= {ALUResult_ALU[31:2], 2'b00};
                        lo_q    <= ALUResult_ALU[1:0];
                        we_q    <= MemWrite;
                        be_q    <= st_be;
                        wdata_q <= st_wdata;
                        f3_q    <= funct3;
                        cnt_q   <= '0;
                        req_q   <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A ready on the final allowed cycle still completes normally.
                    if (mem_ready) begin
                        req_q   <= 1'b0;
                        data_q  <= we_q ? 32'h0 : ld_data;
                        state_q <= ST_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        req_q     <= 1'b0;
                        data_q    <= 32'h0;
                        bus_err_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_req        = req_q;
    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_be         = be_q;
    assign mem_wdata      = wdata_q;
    assign Stall_LSU      = issue || (state_q == ST_REQ);
    assign Misaligned_LSU = (state_q == ST_IDLE) && illegal;
    assign BusError_LSU   = bus_err_q;
    assign ReadData_LSU   = (state_q == ST_DONE) ? data_q : 32'h0;

endmodule
